dcache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits between the datapath's load/store port and the D-memory interface of the word-addressed memory block.
- Acts as the initiator of the memory's 2-cycle readM/writeM protocol.
- Refills whole 4-word lines (64 bits) on read misses and keeps hit/miss statistics.

---
 rtl/dcache_ctrl.sv | 148 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Drives the memory block's 2-cycle readM/writeM protocol and refills whole lines on load misses.
module dcache_ctrl #(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_LINES  = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 mem_readM,
    output logic                 mem_writeM,
    output logic [WORD_SIZE-1:0] mem_address,
    inout  wire  [WORD_SIZE-1:0] mem_data,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, FILL_REQ, FILL_WAIT, FILL_DATA, WR_REQ, WR_GAP, RESP
    } state_t;

    state_t state, state_d;

    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 we_q;
    logic                 hit_q;
    logic [OFF_W-1:0]     fill_cnt;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [WORD_SIZE-1:0] data_mem [NUM_LINES][LINE_WORDS];

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             last_word;

    assign off       = addr_q[OFF_W-1:0];
    assign idx       = addr_q[OFF_W +: IDX_W];
    assign tag       = addr_q[WORD_SIZE-1 -: TAG_W];
    assign hit       = valid[idx] && (tag_mem[idx] == tag);
    assign last_word = (fill_cnt == OFF_W'(LINE_WORDS - 1));

    // The bus is only ours while the write strobe is up.
    assign mem_data = (state == WR_REQ) ? wdata_q : 'z;

    always_comb begin
        // NOTE: state_d gets a default before the case, so no path leaves it unassigned and no latch is inferred.
        state_d = state;
        case (state)
            IDLE:      if (cpu_req) state_d = LOOKUP;
            LOOKUP: begin
                if (we_q)     state_d = WR_REQ;
                else if (hit) state_d = RESP;
                else          state_d = FILL_REQ;
            end
            FILL_REQ:  state_d = FILL_WAIT;
            FILL_WAIT: state_d = FILL_DATA;
            FILL_DATA: state_d = last_word ? RESP : FILL_REQ;
            WR_REQ:    state_d = WR_GAP;
            WR_GAP:    state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // NOTE: clocked blocks use only <=, so every register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            hit_q       <= 1'b0;
            fill_cnt    <= '0;
            valid       <= '0;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= '0;
            mem_readM   <= 1'b0;
            mem_writeM  <= 1'b0;
            mem_address <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            state      <= state_d;
            // Registered strobes are decoded from the state being entered.
            cpu_ready  <= (state_d == RESP);
            mem_readM  <= (state_d == FILL_REQ);
            mem_writeM <= (state_d == WR_REQ);
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                    end
                end
                LOOKUP: begin
                    hit_q <= hit;
                    if (hit) hit_count  <= hit_count + 1'b1;
                    else     miss_count <= miss_count + 1'b1;
                    if (we_q) begin
                        mem_address <= addr_q;
                    end else if (hit) begin
                        cpu_rdata <= data_mem[idx][off];
                    end else begin
                        // The victim line is dropped now so an aborted refill never looks valid.
                        valid[idx]  <= 1'b0;
                        fill_cnt    <= '0;
                        mem_address <= {addr_q[WORD_SIZE-1:OFF_W], OFF_W'(0)};
                    end
                end
                FILL_DATA: begin
                    if (last_word) begin
                        valid[idx] <= 1'b1;
                        cpu_rdata  <= (off == fill_cnt) ? mem_data : data_mem[idx][off];
                    end else begin
                        fill_cnt    <= fill_cnt + 1'b1;
                        mem_address <= {addr_q[WORD_SIZE-1:OFF_W], fill_cnt + 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; the valid bits alone decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (state == FILL_DATA) begin
            data_mem[idx][fill_cnt] <= mem_data;
            if (last_word) tag_mem[idx] <= tag;
        end
        if (state == WR_REQ && hit_q) data_mem[idx][off] <= wdata_q;
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a word memory answering the 2-cycle protocol,
// plus a line-level cache model that predicts hit/miss, latency, load data and strobes.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_readM;
    logic        mem_writeM;
    logic [15:0] mem_address;
    wire  [15:0] mem_data;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic        tb_drv_en;
    logic [15:0] tb_drv_data;
    assign mem_data = tb_drv_en ? tb_drv_data : 'z;

    always #5 clk = ~clk;

    dcache_ctrl #(.WORD_SIZE(16), .NUM_LINES(4), .LINE_WORDS(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .mem_readM   (mem_readM),
        .mem_writeM  (mem_writeM),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Memory block written by the DUT, and the model's own copy of what memory should hold.
    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    logic [15:0] rd_log[$];
    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];

    initial begin : memory_block
        logic [15:0] ra;
        tb_drv_en   = 1'b0;
        tb_drv_data = '0;
        forever begin
            @(negedge clk);
            if (reset_n && mem_writeM === 1'b1) begin
                mem[mem_address[7:0]] = mem_data;
                wr_addr_log.push_back(mem_address);
                wr_data_log.push_back(mem_data);
            end
            if (reset_n && mem_readM === 1'b1) begin
                ra = mem_address;
                rd_log.push_back(ra);
                @(posedge clk);
                @(posedge clk);
                #1;
                tb_drv_en   = 1'b1;
                tb_drv_data = mem[ra[7:0]];
                @(posedge clk);
                #1;
                tb_drv_en   = 1'b0;
            end
        end
    end

    // Protocol invariants checked every cycle outside reset.
    initial begin : monitor
        logic prev_ready;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("strobe_exclusive", 32'(mem_readM & mem_writeM), 32'd0);
                if (!tb_drv_en && !mem_writeM)
                    check("bus_released", 32'(mem_data === 16'hzzzz), 32'd1);
                if (prev_ready)
                    check("ready_single_cycle", 32'(cpu_ready), 32'd0);
                prev_ready = cpu_ready;
            end else begin
                prev_ready = 1'b0;
            end
        end
    end

    // Cache model: which tag each line holds, plus expected counters and last load data.
    logic        m_valid [4];
    logic [11:0] m_tag   [4];
    int          m_hits;
    int          m_misses;
    logic [15:0] m_rdata;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        m_rdata  = '0;
    endtask

    task automatic access(input string nm, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, output int lat, output logic [15:0] rdata);
        int          idx;
        logic [11:0] tg;
        logic        hit;
        int          exp_lat;
        int          exp_reads;
        idx = int'(addr[3:2]);
        tg  = addr[15:4];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (hit) m_hits++;
        else     m_misses++;
        if (we) begin
            exp_lat = 4;
            exp_reads = 0;
            ref_mem[addr[7:0]] = wdata;
        end else begin
            exp_lat   = hit ? 2 : 14;
            exp_reads = hit ? 0 : 4;
            m_rdata   = ref_mem[addr[7:0]];
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end

        @(negedge clk);
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk);
        #1;
        cpu_we    = ~we;
        cpu_addr  = ~addr;
        cpu_wdata = ~wdata;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (cpu_ready) break;
        end
        rdata   = cpu_rdata;
        cpu_req = 1'b0;

        check({nm, ".latency"}, 32'(lat), 32'(exp_lat));
        check({nm, ".rdata"}, 32'(cpu_rdata), 32'(m_rdata));
        check({nm, ".hit_count"}, 32'(hit_count), 32'(m_hits));
        check({nm, ".miss_count"}, 32'(miss_count), 32'(m_misses));
        check({nm, ".read_pulses"}, 32'(rd_log.size()), 32'(exp_reads));
        for (int i = 0; i < rd_log.size() && i < 4; i++)
            check($sformatf("%s.read_addr%0d", nm, i), 32'(rd_log[i]), 32'({addr[15:2], 2'(i)}));
        check({nm, ".write_pulses"}, 32'(wr_addr_log.size()), 32'(we));
        if (we && wr_addr_log.size() > 0) begin
            check({nm, ".write_addr"}, 32'(wr_addr_log[0]), 32'(addr));
            check({nm, ".write_data"}, 32'(wr_data_log[0]), 32'(wdata));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          lat;
        logic [15:0] rd;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'hA000 + 16'(i);
            ref_mem[i] = 16'hA000 + 16'(i);
        end
        mem[8'h24] = 16'hF01C;  ref_mem[8'h24] = 16'hF01C;
        mem[8'h26] = 16'hF41C;  ref_mem[8'h26] = 16'hF41C;

        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset.cpu_ready", 32'(cpu_ready), 32'd0);
        check("reset.cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("reset.mem_readM", 32'(mem_readM), 32'd0);
        check("reset.mem_writeM", 32'(mem_writeM), 32'd0);
        check("reset.mem_address", 32'(mem_address), 32'd0);
        check("reset.hit_count", 32'(hit_count), 32'd0);
        check("reset.miss_count", 32'(miss_count), 32'd0);
        check("reset.mem_data_z", 32'(mem_data === 16'hzzzz), 32'd1);
        reset_n = 1'b1;

        // Idle with no request: nothing should happen.
        repeat (3) @(negedge clk);
        check("idle.no_ready", 32'(cpu_ready), 32'd0);
        check("idle.no_read", 32'(mem_readM), 32'd0);

        access("ld24_miss", 1'b0, 16'h0024, 16'h0000, lat, rd);
        check("pin.ld24_latency", 32'(lat), 32'd14);
        check("pin.ld24_rdata", 32'(rd), 32'hF01C);

        access("ld26_hit", 1'b0, 16'h0026, 16'h0000, lat, rd);
        check("pin.ld26_latency", 32'(lat), 32'd2);
        check("pin.ld26_rdata", 32'(rd), 32'hF41C);
        check("pin.ld26_hits", 32'(hit_count), 32'd1);

        access("st25_hit", 1'b1, 16'h0025, 16'h1234, lat, rd);
        check("pin.st25_latency", 32'(lat), 32'd4);
        check("pin.st25_hits", 32'(hit_count), 32'd2);
        access("ld25_hit", 1'b0, 16'h0025, 16'h0000, lat, rd);
        check("pin.ld25_rdata", 32'(rd), 32'h1234);
        check("pin.mem25", 32'(mem[8'h25]), 32'h1234);

        access("ld64_evict", 1'b0, 16'h0064, 16'h0000, lat, rd);
        access("ld24_again", 1'b0, 16'h0024, 16'h0000, lat, rd);
        check("pin.evict_misses", 32'(miss_count), 32'd3);
        check("pin.evict_rdata", 32'(rd), 32'hF01C);

        access("st00_miss", 1'b1, 16'h0000, 16'hBEEF, lat, rd);
        check("pin.mem00", 32'(mem[8'h00]), 32'hBEEF);
        access("ld00_miss", 1'b0, 16'h0000, 16'h0000, lat, rd);
        check("pin.ld00_latency", 32'(lat), 32'd14);
        check("pin.ld00_rdata", 32'(rd), 32'hBEEF);

        access("ld67_miss_last", 1'b0, 16'h0067, 16'h0000, lat, rd);
        check("pin.ld67_rdata", 32'(rd), 32'hA067);

        // Reset during the FILL_WAIT cycle of the second word of a refill.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0024;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 5) check("abort.second_read_pulse", 32'(mem_readM), 32'd1);
        end
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("abort.mem_readM", 32'(mem_readM), 32'd0);
        check("abort.mem_writeM", 32'(mem_writeM), 32'd0);
        check("abort.mem_address", 32'(mem_address), 32'd0);
        check("abort.cpu_ready", 32'(cpu_ready), 32'd0);
        check("abort.hit_count", 32'(hit_count), 32'd0);
        check("abort.miss_count", 32'(miss_count), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        access("post_reset_ld24", 1'b0, 16'h0024, 16'h0000, lat, rd);
        check("pin.post_reset_misses", 32'(miss_count), 32'd1);
        check("pin.post_reset_latency", 32'(lat), 32'd14);
        access("post_reset_ld26", 1'b0, 16'h0026, 16'h0000, lat, rd);
        check("pin.post_reset_hits", 32'(hit_count), 32'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
